optic_flow_grad_seq_ci: RTL and testbench
=========================================

Name: optic_flow_grad_seq_ci

Overview:
- Streaming sequencer that drives the optic-flow gradient-threshold datapath over a whole frame.
- Accepts 8-bit grayscale pixels in raster order and keeps two line buffers plus a column delay.
- For every interior pixel it forms left/right/up/down neighbours and computes flags {dy,dx} = {|up-down| > T, |right-left| > T}.
- Packs 16 flag pairs per 32-bit output word. Configured and started by software through the CPU custom-instruction interface.

Parameters:
customInstructionId, 8'd0, CI number this block responds to
MAX_WIDTH, 640, line-buffer depth; largest frame width in pixels
DEFAULT_THRESHOLD, 8'd10, threshold T after reset

Ports:
clock  in  1  system clock
resetN  in  1  asynchronous active-low reset
ciStart  in  1  CI start strobe
ciN  in  8  CI number
ciValueA  in  32  command: [1:0] 0=setWidth, 1=setThreshold, 2=startFrame, 3=readStatus
ciValueB  in  32  command argument
ciDone  out  1  CI completion pulse
ciResult  out  32  CI return value
pixelValid  in  1  input pixel valid
pixelData  in  8  grayscale pixel
pixelReady  out  1  pixel accepted when pixelValid && pixelReady
outValid  out  1  packed flag word valid
outData  out  32  packed flags; pair k at bits [2k+1:2k] = {dy,dx}
outReady  in  1  downstream accepts word
frameDone  out  1  one-cycle pulse when frame fully emitted

Behaviour:
- Reset values: ciDone=0, ciResult=0, pixelReady=0, outValid=0, outData=0, frameDone=0.
  - Internal reset values: width=MAX_WIDTH, height=0, T=DEFAULT_THRESHOLD, state=IDLE, error=0.
- CI timing: active = ciStart && ciN==customInstructionId. ciDone pulses exactly one cycle after active; ciResult is valid in that cycle and 0 otherwise.
- setWidth: width=ciValueB[9:0]. Result 0; result 1 (rejected) if busy or width<3 or width>MAX_WIDTH.
- setThreshold: T=ciValueB[7:0]. Result 0; result 1 if busy.
- startFrame: height=ciValueB[9:0]. Result 0 and IDLE->RUN when not busy and height>=3.
  - Otherwise result 1, error=1, stay in current state.
- readStatus: result {error, busy, 14'd0, wordsEmitted[15:0]}. Reading clears error.
- busy = state != IDLE.
- States:
  - IDLE: pixelReady=0. Counters x, y, pack index and wordsEmitted cleared on entry to RUN.
  - RUN: pixelReady = !(outValid && !outReady). On each pixel handshake at (y,x), write the pixel into the line buffer and evaluate centre (y-1,x-1):
    - left=(y-1,x-2), right=(y-1,x), up=(y-2,x-1), down=(y,x-1).
    - Evaluate only when y>=2 and x>=2; centres run over rows 1..H-2 and cols 1..W-2.
    - x wraps to 0 at width-1 and y increments. The last pixel (height-1,width-1) moves the state to FLUSH.
  - FLUSH: if pack index != 0, present the zero-padded partial word; after its handshake go to IDLE. If pack index == 0, go to IDLE directly.
    - frameDone pulses in the cycle the IDLE transition is taken.
- Arithmetic: 8-bit unsigned compare of larger minus smaller; the comparison is strict > T. T=255 therefore yields all-zero flags.
- Packing:
  - The flag pair is written to pack slot index in the cycle after the pixel handshake.
  - On slot 15, the word is loaded into the outData register with outValid=1 in the following cycle and the pack index returns to 0.
  - outValid holds, with outData stable, until outReady. wordsEmitted increments on each output handshake.
- Backpressure: only one output word is buffered. While outValid && !outReady, pixelReady=0, so no pack slot overflow is possible.
- Total words = ceil((W-2)*(H-2)/16).
- Reset mid-frame: everything returns to reset values immediately. Line-buffer contents are don't-care; partial results are discarded.

Test Plan:
- Flat frame, W=4, H=4, all pixels 50, T=10 -> one word 0x00000000 (4 pairs plus padding); frameDone pulse; status wordsEmitted=1.
- W=4, H=4, pixel=20*x, T=10 -> dx=1, dy=0 for all 4 centres -> outData=0x00000055.
- Threshold boundary: W=4, H=4, pixel=6*x (|right-left|=12) -> 0x55 at T=11, 0x00 at T=12. Pixel=6*y with T=11 -> 0xAA.
- Full word, no padding: W=18, H=3, pixel=20*x -> exactly one word 0x55555555. FLUSH emits nothing extra; frameDone follows directly.
- Backpressure: W=34, H=3 with outReady held low 20 cycles after the first outValid -> pixelReady=0 throughout and outData stable. After release, 2 words are emitted in order.
- Errors and reset:
  - setWidth(2) -> ciResult=1; startFrame(2) -> ciResult=1 and readStatus bit31=1, then 0 on re-read.
  - startFrame while RUN -> ciResult=1.
  - resetN low mid-frame -> all outputs 0, state IDLE, width=MAX_WIDTH.

Source files
------------

// File: rtl/optic_flow_grad_seq_ci_if.sv
// Bundle of CI, pixel-in and flag-word-out signals for the optic-flow gradient sequencer.
// Clock and reset stay outside the bundle as plain ports on the sequencer.
interface optic_flow_grad_seq_ci_if;
  logic        ciStart;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;
  logic        pixelValid;
  logic [7:0]  pixelData;
  logic        pixelReady;
  logic        outValid;
  logic [31:0] outData;
  logic        outReady;
  logic        frameDone;

  modport slave (
    input  ciStart, ciN, ciValueA, ciValueB, pixelValid, pixelData, outReady,
    output ciDone, ciResult, pixelReady, outValid, outData, frameDone
  );

  modport master (
    output ciStart, ciN, ciValueA, ciValueB, pixelValid, pixelData, outReady,
    input  ciDone, ciResult, pixelReady, outValid, outData, frameDone
  );
endinterface

// File: rtl/optic_flow_grad_seq_ci.sv
// Frame sequencer for the gradient-threshold datapath: line-buffers raster pixels, flags
// |right-left| and |up-down| above T per interior pixel, and packs 16 flag pairs per word.
module optic_flow_grad_seq_ci #(
  parameter logic [7:0]  customInstructionId = 8'd0,
  parameter int unsigned MAX_WIDTH           = 640,
  parameter logic [7:0]  DEFAULT_THRESHOLD   = 8'd10
) (
  input  logic                         clock,
  input  logic                         resetN,
  optic_flow_grad_seq_ci_if.slave      bus
);

  localparam int unsigned DIM_W = 10;
  localparam int unsigned AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [7:0]        thr_q, thr_d;
  logic              error_q, error_d;
  logic [DIM_W-1:0]  x_q, x_d;
  logic [DIM_W-1:0]  y_q, y_d;
  logic [3:0]        pack_idx_q, pack_idx_d;
  logic [31:0]       pack_q, pack_d;
  logic [15:0]       words_q, words_d;
  logic [7:0]        ctr_q, ctr_d;
  logic [7:0]        left_q, left_d;
  logic [7:0]        up_q, up_d;
  logic [7:0]        down_q, down_d;
  logic [1:0]        flag_q, flag_d;
  logic              flag_vld_q, flag_vld_d;
  logic              ci_done_q, ci_done_d;
  logic [31:0]       ci_result_q, ci_result_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              frame_done_q, frame_done_d;

  logic [7:0]        lb0_q [MAX_WIDTH];
  logic [7:0]        lb1_q [MAX_WIDTH];

  logic              ci_active;
  logic              busy;
  logic              pix_hs;
  logic [AW-1:0]     x_idx;
  logic [7:0]        right_rd;
  logic [7:0]        up_rd;
  logic [7:0]        diff_x;
  logic [7:0]        diff_y;
  logic [DIM_W-1:0]  arg_dim;
  logic              unused_bits;

  assign ci_active = bus.ciStart && (bus.ciN == customInstructionId);
  assign busy      = (state_q != S_IDLE);
  assign bus.pixelReady = (state_q == S_RUN) && !(out_valid_q && !bus.outReady);
  assign pix_hs    = bus.pixelValid && bus.pixelReady;
  assign x_idx     = AW'(x_q);
  assign right_rd  = lb0_q[x_idx];
  assign up_rd     = lb1_q[x_idx];
  assign arg_dim   = bus.ciValueB[DIM_W-1:0];
  assign unused_bits = ^{bus.ciValueA[31:2], bus.ciValueB[31:DIM_W]};

  // left comes from the column delay of row y-1, down is the previous pixel of row y
  assign diff_x = (right_rd >= left_q) ? (right_rd - left_q) : (left_q - right_rd);
  assign diff_y = (up_q >= down_q) ? (up_q - down_q) : (down_q - up_q);

  // Row y-1 lives in lb0, row y-2 in lb1; both shift down one row per written column.
  always_ff @(posedge clock) begin
    if (pix_hs) begin
      lb0_q[x_idx] <= bus.pixelData;
      lb1_q[x_idx] <= right_rd;
    end
  end

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    thr_d        = thr_q;
    error_d      = error_q;
    x_d          = x_q;
    y_d          = y_q;
    pack_idx_d   = pack_idx_q;
    pack_d       = pack_q;
    words_d      = words_q;
    ctr_d        = ctr_q;
    left_d       = left_q;
    up_d         = up_q;
    down_d       = down_q;
    flag_d       = flag_q;
    flag_vld_d   = 1'b0;
    ci_done_d    = ci_active;
    ci_result_d  = 32'd0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;

    if (out_valid_q && bus.outReady) begin
      out_valid_d = 1'b0;
      words_d     = words_q + 16'd1;
    end

    // Pack stage: a full word moves to the output register, the packer restarts at slot 0
    if (flag_vld_q) begin
      pack_d = pack_q | (32'(flag_q) << {pack_idx_q, 1'b0});
      if (pack_idx_q == 4'd15) begin
        out_data_d  = pack_d;
        out_valid_d = 1'b1;
        pack_d      = 32'd0;
        pack_idx_d  = 4'd0;
      end else begin
        pack_idx_d  = pack_idx_q + 4'd1;
      end
    end

    case (state_q)
      S_RUN: begin
        if (pix_hs) begin
          ctr_d  = right_rd;
          left_d = ctr_q;
          up_d   = up_rd;
          down_d = bus.pixelData;
          if ((y_q >= 10'd2) && (x_q >= 10'd2)) begin
            flag_vld_d = 1'b1;
            flag_d     = {diff_y > thr_q, diff_x > thr_q};
          end
          if (x_q == width_q - 10'd1) begin
            x_d = 10'd0;
            y_d = y_q + 10'd1;
            if (y_q == height_q - 10'd1) state_d = S_FLUSH;
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      S_FLUSH: begin
        // Wait for the last flag to be packed and any full word to drain first
        if (!flag_vld_q && !out_valid_q) begin
          if (pack_idx_q != 4'd0) begin
            out_data_d  = pack_q;
            out_valid_d = 1'b1;
            pack_d      = 32'd0;
            pack_idx_d  = 4'd0;
          end else begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (ci_active) begin
      case (bus.ciValueA[1:0])
        2'd0: begin
          if (busy || (arg_dim < 10'd3) || ({22'd0, arg_dim} > 32'(MAX_WIDTH))) ci_result_d = 32'd1;
          else width_d = arg_dim;
        end
        2'd1: begin
          if (busy) ci_result_d = 32'd1;
          else thr_d = bus.ciValueB[7:0];
        end
        2'd2: begin
          if (busy || (arg_dim < 10'd3)) begin
            ci_result_d = 32'd1;
            error_d     = 1'b1;
          end else begin
            state_d    = S_RUN;
            height_d   = arg_dim;
            x_d        = 10'd0;
            y_d        = 10'd0;
            pack_idx_d = 4'd0;
            pack_d     = 32'd0;
            words_d    = 16'd0;
            flag_vld_d = 1'b0;
          end
        end
        default: begin
          ci_result_d = {error_q, busy, 14'd0, words_q};
          error_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      width_q      <= DIM_W'(MAX_WIDTH);
      height_q     <= 10'd0;
      thr_q        <= DEFAULT_THRESHOLD;
      error_q      <= 1'b0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      pack_idx_q   <= 4'd0;
      pack_q       <= 32'd0;
      words_q      <= 16'd0;
      ctr_q        <= 8'd0;
      left_q       <= 8'd0;
      up_q         <= 8'd0;
      down_q       <= 8'd0;
      flag_q       <= 2'd0;
      flag_vld_q   <= 1'b0;
      ci_done_q    <= 1'b0;
      ci_result_q  <= 32'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      thr_q        <= thr_d;
      error_q      <= error_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pack_idx_q   <= pack_idx_d;
      pack_q       <= pack_d;
      words_q      <= words_d;
      ctr_q        <= ctr_d;
      left_q       <= left_d;
      up_q         <= up_d;
      down_q       <= down_d;
      flag_q       <= flag_d;
      flag_vld_q   <= flag_vld_d;
      ci_done_q    <= ci_done_d;
      ci_result_q  <= ci_result_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.ciDone    = ci_done_q;
  assign bus.ciResult  = ci_result_q;
  assign bus.outValid  = out_valid_q;
  assign bus.outData   = out_data_q;
  assign bus.frameDone = frame_done_q;

endmodule

// File: tb/tb_optic_flow_grad_seq_ci.sv
// Directed bench for optic_flow_grad_seq_ci: frames are driven pixel by pixel while a
// reference image model queues the expected flag words, which are popped on each output handshake.
module tb_optic_flow_grad_seq_ci;

  logic clock = 1'b0;
  logic resetN;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_q [$];

  optic_flow_grad_seq_ci_if bus ();

  optic_flow_grad_seq_ci #(
    .customInstructionId (8'd0),
    .MAX_WIDTH           (640),
    .DEFAULT_THRESHOLD   (8'd10)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int x, input int y);
    case (mode)
      0:       return 8'd50;
      1:       return 8'(20 * x);
      2:       return 8'(6 * x);
      3:       return 8'(6 * y);
      default: return 8'(((x * 37) + (y * 91) + (x * y)) ^ 8'h5a);
    endcase
  endfunction

  function automatic int absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
  endfunction

  // Reference: walk interior centres in raster order, two flag bits per centre, 16 per word
  task automatic push_model(input int w, input int h, input int t, input int mode, output int nwords);
    logic [31:0] word;
    int slot;
    word = 32'd0;
    slot = 0;
    nwords = 0;
    for (int r = 1; r <= h - 2; r++) begin
      for (int c = 1; c <= w - 2; c++) begin
        logic dx, dy;
        dx = absdiff(pix(mode, c + 1, r), pix(mode, c - 1, r)) > t;
        dy = absdiff(pix(mode, c, r - 1), pix(mode, c, r + 1)) > t;
        word[2*slot +: 2] = {dy, dx};
        slot++;
        if (slot == 16) begin
          exp_q.push_back(word);
          nwords++;
          word = 32'd0;
          slot = 0;
        end
      end
    end
    if (slot != 0) begin
      exp_q.push_back(word);
      nwords++;
    end
  endtask

  task automatic ci_raw(input logic [7:0] n, input logic [1:0] op, input logic [31:0] arg,
                        output logic done, output logic [31:0] res);
    @(negedge clock);
    bus.ciStart  = 1'b1;
    bus.ciN      = n;
    bus.ciValueA = {30'd0, op};
    bus.ciValueB = arg;
    @(negedge clock);
    bus.ciStart = 1'b0;
    done = bus.ciDone;
    res  = bus.ciResult;
    @(negedge clock);
    check32("ci_done_drop", {31'd0, bus.ciDone}, 32'd0);
    check32("ci_result_idle", bus.ciResult, 32'd0);
  endtask

  task automatic ci(input logic [1:0] op, input logic [31:0] arg, output logic [31:0] res);
    logic done;
    ci_raw(8'd0, op, arg, done, res);
    check32("ci_done", {31'd0, done}, 32'd1);
  endtask

  // Stream one whole frame; with bp set, outReady is held low until 20 cycles past the first word
  task automatic stream_frame(input int w, input int h, input int mode, input bit bp, input int nwords);
    int px, cyc, stall_left;
    bit fd, ph, oh;
    logic [31:0] held, res;
    px = 0;
    cyc = 0;
    fd = 1'b0;
    stall_left = -1;
    held = 32'd0;
    @(posedge clock);
    #1;
    bus.pixelValid = 1'b1;
    bus.pixelData  = pix(mode, 0, 0);
    bus.outReady   = !bp;
    while (!fd) begin
      @(negedge clock);
      cyc++;
      ph = bus.pixelValid && bus.pixelReady;
      oh = bus.outValid && bus.outReady;
      if (bp && (stall_left < 0) && bus.outValid) begin
        stall_left = 20;
        held = bus.outData;
      end
      if (bp && bus.outValid && !bus.outReady) begin
        check32("bp_pixel_ready", {31'd0, bus.pixelReady}, 32'd0);
        check32("bp_out_hold", bus.outData, held);
      end
      if (oh) begin
        check32("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check32("out_word", bus.outData, exp_q.pop_front());
      end
      if (bus.frameDone) fd = 1'b1;
      if (cyc >= 20000) begin
        check32("frame_timeout", {31'd0, fd}, 32'd1);
        break;
      end
      if (!fd) begin
        @(posedge clock);
        #1;
        if (ph) begin
          px++;
          if (px == w * h) bus.pixelValid = 1'b0;
          else bus.pixelData = pix(mode, px % w, px / w);
        end
        if (stall_left > 0) stall_left--;
        bus.outReady = !(bp && (stall_left != 0));
      end
    end
    check32("pixels_taken", px, w * h);
    check32("sb_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clock);
    check32("frame_done_pulse", {31'd0, bus.frameDone}, 32'd0);
    bus.outReady = 1'b1;
    ci(2'd3, 32'd0, res);
    check32("status_words", res, {16'd0, 16'(nwords)});
  endtask

  task automatic run_frame(input int w, input int h, input int t, input int mode, input bit bp);
    logic [31:0] res;
    int nwords;
    ci(2'd0, 32'(w), res);
    check32("set_width", res, 32'd0);
    ci(2'd1, 32'(t), res);
    check32("set_threshold", res, 32'd0);
    push_model(w, h, t, mode, nwords);
    ci(2'd2, 32'(h), res);
    check32("start_frame", res, 32'd0);
    stream_frame(w, h, mode, bp, nwords);
  endtask

  initial begin
    logic [31:0] res;
    logic        done;
    int          nwords;

    resetN         = 1'b0;
    bus.ciStart    = 1'b0;
    bus.ciN        = 8'd0;
    bus.ciValueA   = 32'd0;
    bus.ciValueB   = 32'd0;
    bus.pixelValid = 1'b0;
    bus.pixelData  = 8'd0;
    bus.outReady   = 1'b1;
    repeat (3) @(negedge clock);
    check32("rst_outputs", {bus.ciDone, bus.pixelReady, bus.outValid, bus.frameDone}, 32'd0);
    check32("rst_ci_result", bus.ciResult, 32'd0);
    check32("rst_out_data", bus.outData, 32'd0);
    resetN = 1'b1;

    ci_raw(8'd5, 2'd3, 32'd0, done, res);
    check32("foreign_ci_no_done", {31'd0, done}, 32'd0);

    run_frame(4, 4, 10, 0, 1'b0);
    run_frame(4, 4, 10, 1, 1'b0);
    run_frame(4, 4, 11, 2, 1'b0);
    run_frame(4, 4, 12, 2, 1'b0);
    run_frame(4, 4, 11, 3, 1'b0);
    run_frame(4, 4, 255, 4, 1'b0);
    run_frame(18, 3, 10, 1, 1'b0);
    run_frame(34, 3, 10, 1, 1'b1);
    run_frame(7, 5, 30, 4, 1'b0);

    ci(2'd0, 32'd2, res);
    check32("set_width_2", res, 32'd1);
    ci(2'd0, 32'd641, res);
    check32("set_width_641", res, 32'd1);
    ci(2'd2, 32'd2, res);
    check32("start_h2", res, 32'd1);
    ci(2'd3, 32'd0, res);
    check32("status_error", {31'd0, res[31]}, 32'd1);
    ci(2'd3, 32'd0, res);
    check32("status_error_cleared", {31'd0, res[31]}, 32'd0);

    ci(2'd0, 32'd8, res);
    ci(2'd2, 32'd4, res);
    check32("start_ok", res, 32'd0);
    ci(2'd2, 32'd4, res);
    check32("start_while_run", res, 32'd1);
    ci(2'd1, 32'd3, res);
    check32("thr_while_run", res, 32'd1);
    ci(2'd3, 32'd0, res);
    check32("status_busy_err", res, 32'hC000_0000);

    @(posedge clock);
    #1;
    bus.pixelValid = 1'b1;
    bus.pixelData  = 8'd77;
    repeat (12) @(posedge clock);
    #2;
    resetN = 1'b0;
    #1;
    check32("midrst_outputs", {bus.ciDone, bus.pixelReady, bus.outValid, bus.frameDone}, 32'd0);
    check32("midrst_out_data", bus.outData, 32'd0);
    check32("midrst_ci_result", bus.ciResult, 32'd0);
    bus.pixelValid = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    ci(2'd3, 32'd0, res);
    check32("midrst_status", res, 32'd0);

    // Width and threshold left at their reset values
    push_model(640, 3, 10, 4, nwords);
    ci(2'd2, 32'd3, res);
    check32("start_default_w", res, 32'd0);
    stream_frame(640, 3, 4, 1'b0, nwords);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
